ram_burst_ctrl: RTL and testbench
=================================

// Module: ram_burst_ctrl
// PURPOSE
//   Burst command sequencer sitting directly upstream of the single-port RAM.
//   Accepts write/read burst commands over a valid/ready handshake. Drives the RAM
//   enable, write-enable, read-enable, address and write-data pins one beat per cycle.
//   Returns read data as a valid-qualified stream.
// PARAMETERS
//   DATA_WIDTH   8  RAM word width, bits
//   ADDR_WIDTH   4  RAM address width; depth = 2**ADDR_WIDTH words
//   RD_LATENCY   1  cycles from RAM read strobe to valid data on i_rdata_ram (>=1)
// PORTS
//   i_clk_ctrl    in   1           single clock; all logic on rising edge
//   i_rst_ctrl    in   1           synchronous, active-high reset
//   i_cmd_valid   in   1           command offered
//   o_cmd_ready   out  1           controller idle, command can be accepted
//   i_cmd_wr      in   1           1 = write burst, 0 = read burst
//   i_cmd_addr    in   ADDR_WIDTH  burst start address
//   i_cmd_len     in   ADDR_WIDTH  beats minus one (0 -> 1 beat, max -> 2**ADDR_WIDTH beats)
//   i_wdata       in   DATA_WIDTH  write stream data
//   i_wvalid      in   1           write beat offered
//   o_wready      out  1           write beat accepted when i_wvalid & o_wready
//   o_rdata       out  DATA_WIDTH  read stream data (valid only with o_rvalid)
//   o_rvalid      out  1           read beat valid; no backpressure, consumer must take it
//   o_busy        out  1           burst in progress (state != IDLE)
//   o_done        out  1           one-cycle pulse on final beat of a burst
//   o_addr_ram    out  ADDR_WIDTH  RAM address
//   o_wdata_ram   out  DATA_WIDTH  RAM write data
//   o_en_ram      out  1           RAM enable
//   o_we_ram      out  1           RAM write enable
//   o_re_ram      out  1           RAM read enable
//   i_rdata_ram   in   DATA_WIDTH  RAM read data
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0 except o_cmd_ready=1; beat counter, address
//     register and read-valid pipeline cleared. Takes priority over every other event.
//   FSM: IDLE -> WRITE or READ on i_cmd_valid & o_cmd_ready (latch wr/addr/len).
//     WRITE -> IDLE after last beat. READ -> DRAIN after last strobe.
//     DRAIN -> IDLE after last o_rvalid.
//   o_cmd_ready = (state==IDLE). Commands offered while busy are ignored, not queued.
//   RAM pins are registered; any cycle without a strobe: o_en/we/re_ram=0,
//     o_addr_ram and o_wdata_ram hold their last values.
//   WRITE: o_wready=1 throughout. Each accepted beat produces, next cycle, one RAM
//     cycle: en=1, we=1, re=0, addr=current, wdata=beat. i_wvalid low -> no strobe,
//     address holds (stall). Total strobes = i_cmd_len+1.
//   READ: strobe every cycle starting the cycle after acceptance: en=1, re=1, we=0.
//     Stop after i_cmd_len+1 strobes. o_wready=0 in READ and DRAIN.
//   Read return: o_rvalid is high exactly RD_LATENCY cycles after each o_re_ram cycle,
//     via a RD_LATENCY-deep valid shift register; o_rdata = i_rdata_ram in that cycle.
//   Address: start at i_cmd_addr, +1 per beat, wraps modulo 2**ADDR_WIDTH (15 -> 0).
//   o_done: write = cycle of last RAM write strobe; read = cycle of last o_rvalid.
//     o_cmd_ready rises the following cycle. o_busy = !o_cmd_ready.
//   Reset mid-burst: burst abandoned, pending o_rvalid beats dropped, no o_done.
// TESTING (DATA_WIDTH=8, ADDR_WIDTH=4, RD_LATENCY=1)
//   Write addr 0 len 2 data 12,5,15 -> RAM we at addr 0,1,2 with 12,5,15; one o_done.
//   Read addr 0 len 2 after above -> 3 strobes, o_rvalid 3 consecutive cycles
//     with 12,5,15; o_done with 3rd beat.
//   Write addr 14 len 3 data A0..A3 -> RAM addrs 14,15,0,1; readback returns A0..A3.
//   Write len 3, i_wvalid low 2 cycles after beat 1 -> no strobes in gap, addr holds,
//     burst completes with 4 strobes.
//   Command offered during READ -> o_cmd_ready=0, ignored, no extra RAM activity.
//   Reset asserted mid read burst -> next cycle o_rvalid=0, o_en_ram=0,
//     o_cmd_ready=1, no o_done.

Source files
------------

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl
//   Burst command sequencer in front of a single-port RAM. A write or read
//   burst command is taken over a valid/ready handshake. The block then drives
//   one RAM beat per cycle on registered pins, and returns read data as a
//   valid-qualified stream with no backpressure.
//
// Ports
//   i_clk_ctrl / i_rst_ctrl       clock, synchronous active-high reset
//   i_cmd_valid / o_cmd_ready     command handshake (ready only while idle)
//   i_cmd_wr, i_cmd_addr, i_cmd_len
//                                 burst type, start address, beats minus one
//   i_wdata / i_wvalid / o_wready write beat stream
//   o_rdata / o_rvalid            read beat stream
//   o_busy, o_done                burst in progress, last-beat pulse
//   o_addr_ram, o_wdata_ram, o_en_ram, o_we_ram, o_re_ram, i_rdata_ram
//                                 RAM pins
module ram_burst_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                  i_clk_ctrl,
  input  logic                  i_rst_ctrl,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_wr,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [ADDR_WIDTH-1:0] i_cmd_len,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_rvalid,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_addr_ram,
  output logic [DATA_WIDTH-1:0] o_wdata_ram,
  output logic                  o_en_ram,
  output logic                  o_we_ram,
  output logic                  o_re_ram,
  input  logic [DATA_WIDTH-1:0] i_rdata_ram
);

  localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);

  // DRAIN is shared by both burst types: it holds the controller busy until
  // o_done has been shown, so o_cmd_ready rises the cycle after o_done.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  // r_cnt holds the beats still to be issued, minus one.
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [ADDR_WIDTH-1:0] w_cnt_nxt;

  logic                  w_strobe;
  logic                  w_strobe_we;
  logic [ADDR_WIDTH-1:0] w_strobe_addr;
  logic                  w_last_wr;
  logic                  w_last_rd;

  logic                  r_en_ram;
  logic                  r_we_ram;
  logic                  r_re_ram;
  logic [ADDR_WIDTH-1:0] r_addr_ram;
  logic [DATA_WIDTH-1:0] r_wdata_ram;
  logic                  r_re_last;
  logic                  r_wr_done;
  logic [RD_LATENCY-1:0] r_vpipe;
  logic [RD_LATENCY-1:0] r_lpipe;

  assign o_cmd_ready = (r_state == S_IDLE);
  assign o_busy      = ~o_cmd_ready;
  assign o_wready    = (r_state == S_WRITE);
  assign o_en_ram    = r_en_ram;
  assign o_we_ram    = r_we_ram;
  assign o_re_ram    = r_re_ram;
  assign o_addr_ram  = r_addr_ram;
  assign o_wdata_ram = r_wdata_ram;
  assign o_rvalid    = r_vpipe[RD_LATENCY-1];
  // RAM data arrives on the cycle o_rvalid is high; gate it so the stream idles at 0.
  assign o_rdata     = o_rvalid ? i_rdata_ram : '0;
  // A read burst ends when the marker that travels beside the last strobe leaves the valid pipe.
  assign o_done      = r_wr_done | r_lpipe[RD_LATENCY-1];

  // FSM state register
  always_ff @(posedge i_clk_ctrl) begin
    if (i_rst_ctrl) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, next address/count and the RAM strobe for the coming cycle
  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_cnt_nxt     = r_cnt;
    w_strobe      = 1'b0;
    w_strobe_we   = 1'b0;
    w_strobe_addr = r_addr;
    w_last_wr     = 1'b0;
    w_last_rd     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_cmd_valid) begin
          w_addr_nxt = i_cmd_addr;
          w_cnt_nxt  = i_cmd_len;
          if (i_cmd_wr) begin
            w_state_nxt = S_WRITE;
          end else begin
            // A read issues its first strobe straight from the accepting cycle.
            w_strobe      = 1'b1;
            w_strobe_addr = i_cmd_addr;
            w_addr_nxt    = i_cmd_addr + ONE_A;
            if (i_cmd_len == '0) begin
              w_last_rd   = 1'b1;
              w_state_nxt = S_DRAIN;
            end else begin
              w_cnt_nxt   = i_cmd_len - ONE_A;
              w_state_nxt = S_READ;
            end
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WRITE: begin
        if (i_wvalid) begin
          w_strobe    = 1'b1;
          w_strobe_we = 1'b1;
          w_addr_nxt  = r_addr + ONE_A;
          if (r_cnt == '0) begin
            w_last_wr   = 1'b1;
            w_state_nxt = S_DRAIN;
          end else begin
            w_cnt_nxt   = r_cnt - ONE_A;
          end
        end else begin
          w_state_nxt = S_WRITE;
        end
      end
      S_READ: begin
        w_strobe   = 1'b1;
        w_addr_nxt = r_addr + ONE_A;
        if (r_cnt == '0) begin
          w_last_rd   = 1'b1;
          w_state_nxt = S_DRAIN;
        end else begin
          w_cnt_nxt   = r_cnt - ONE_A;
        end
      end
      S_DRAIN: begin
        if (o_done) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: address/count, registered RAM pins, read-valid and last-beat pipes
  always_ff @(posedge i_clk_ctrl) begin
    if (i_rst_ctrl) begin
      r_addr      <= '0;
      r_cnt       <= '0;
      r_en_ram    <= 1'b0;
      r_we_ram    <= 1'b0;
      r_re_ram    <= 1'b0;
      r_addr_ram  <= '0;
      r_wdata_ram <= '0;
      r_re_last   <= 1'b0;
      r_wr_done   <= 1'b0;
      r_vpipe     <= '0;
      r_lpipe     <= '0;
    end else begin
      r_addr    <= w_addr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_en_ram  <= w_strobe;
      r_we_ram  <= w_strobe & w_strobe_we;
      r_re_ram  <= w_strobe & ~w_strobe_we;
      r_re_last <= w_last_rd;
      r_wr_done <= w_last_wr;
      // Address and write data keep their last values on idle cycles.
      if (w_strobe) begin
        r_addr_ram <= w_strobe_addr;
      end
      if (w_strobe & w_strobe_we) begin
        r_wdata_ram <= i_wdata;
      end
      r_vpipe[0] <= r_re_ram;
      r_lpipe[0] <= r_re_last;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_vpipe[i] <= r_vpipe[i-1];
        r_lpipe[i] <= r_lpipe[i-1];
      end
    end
  end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Self-checking bench for ram_burst_ctrl with DATA_WIDTH=8, ADDR_WIDTH=4,
// RD_LATENCY=1, backed by a behavioural single-port RAM with a one-cycle
// read latency.
module tb_ram_burst_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_wr;
  logic [3:0] cmd_addr, cmd_len;
  logic [7:0] wdata;
  logic       wvalid, wready;
  logic [7:0] rdata;
  logic       rvalid, busy, done;
  logic [3:0] addr_ram;
  logic [7:0] wdata_ram;
  logic       en_ram, we_ram, re_ram;
  logic [7:0] rdata_ram;

  logic [7:0] mem [16];

  int n_chk  = 0;
  int n_pass = 0;

  ram_burst_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RD_LATENCY(1)) dut (
    .i_clk_ctrl (clk),
    .i_rst_ctrl (rst),
    .i_cmd_valid(cmd_valid),
    .o_cmd_ready(cmd_ready),
    .i_cmd_wr   (cmd_wr),
    .i_cmd_addr (cmd_addr),
    .i_cmd_len  (cmd_len),
    .i_wdata    (wdata),
    .i_wvalid   (wvalid),
    .o_wready   (wready),
    .o_rdata    (rdata),
    .o_rvalid   (rvalid),
    .o_busy     (busy),
    .o_done     (done),
    .o_addr_ram (addr_ram),
    .o_wdata_ram(wdata_ram),
    .o_en_ram   (en_ram),
    .o_we_ram   (we_ram),
    .o_re_ram   (re_ram),
    .i_rdata_ram(rdata_ram)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: synchronous write, registered read (latency 1).
  always @(posedge clk) begin
    if (en_ram && we_ram) mem[addr_ram] <= wdata_ram;
    if (en_ram && re_ram) rdata_ram <= mem[addr_ram];
  end

  // Monitor sampling on the falling edge, away from the active edge.
  logic [3:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  logic [3:0] rd_addr_q[$];
  logic [7:0] rv_data_q[$];
  int         done_cnt = 0;

  always @(negedge clk) begin
    if (en_ram && we_ram) begin wr_addr_q.push_back(addr_ram); wr_data_q.push_back(wdata_ram); end
    if (en_ram && re_ram) rd_addr_q.push_back(addr_ram);
    if (rvalid) rv_data_q.push_back(rdata);
    if (done) done_cnt++;
  end

  task automatic clear_mon();
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete(); rv_data_q.delete();
    done_cnt = 0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = 4'd0; cmd_len = 4'd0;
    wdata = 8'd0; wvalid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int c = 0; c < 40; c++) begin
      if (cmd_ready) break;
      tick();
    end
    chk(name, cmd_ready, 1'b1);
  endtask

  typedef struct {
    logic       rst, cv, cwr;
    logic [3:0] ca, cl;
    logic [7:0] wd;
    logic       wv;
    logic       rdy, wrdy, en, we, re;
    logic [3:0] aram;
    logic [7:0] wdram;
    logic       rv;
    logic [7:0] rd;
    logic       dn;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [27:0] act_p, exp_p;
    logic [7:0]  wrap_d[4];
    logic [3:0]  wrap_a[4];

    for (int i = 0; i < 16; i++) mem[i] = 8'd0;
    rdata_ram = 8'd0;
    rst = 1'b1;
    idle_inputs();

    //            rst  cv   cwr  ca     cl     wd      wv  | rdy wrdy en   we   re   aram   wdram   rv   rd      done
    vecs.push_back('{1'b1,1'b0,1'b0,4'd0, 4'd0, 8'd0,  1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,4'd0,8'd0, 1'b0,8'd0, 1'b0});
    vecs.push_back('{1'b0,1'b1,1'b1,4'd0, 4'd2, 8'd0,  1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0,4'd0,8'd0, 1'b0,8'd0, 1'b0});
    vecs.push_back('{1'b0,1'b0,1'b0,4'd0, 4'd0, 8'd12, 1'b1, 1'b0,1'b1,1'b1,1'b1,1'b0,4'd0,8'd12,1'b0,8'd0, 1'b0});
    vecs.push_back('{1'b0,1'b0,1'b0,4'd0, 4'd0, 8'd5,  1'b1, 1'b0,1'b1,1'b1,1'b1,1'b0,4'd1,8'd5, 1'b0,8'd0, 1'b0});
    vecs.push_back('{1'b0,1'b0,1'b0,4'd0, 4'd0, 8'd15, 1'b1, 1'b0,1'b0,1'b1,1'b1,1'b0,4'd2,8'd15,1'b0,8'd0, 1'b1});
    vecs.push_back('{1'b0,1'b0,1'b0,4'd0, 4'd0, 8'd0,  1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,4'd2,8'd15,1'b0,8'd0, 1'b0});
    vecs.push_back('{1'b0,1'b1,1'b0,4'd0, 4'd2, 8'd0,  1'b0, 1'b0,1'b0,1'b1,1'b0,1'b1,4'd0,8'd15,1'b0,8'd0, 1'b0});
    vecs.push_back('{1'b0,1'b0,1'b0,4'd0, 4'd0, 8'd0,  1'b0, 1'b0,1'b0,1'b1,1'b0,1'b1,4'd1,8'd15,1'b1,8'd12,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b0,4'd0, 4'd0, 8'd0,  1'b0, 1'b0,1'b0,1'b1,1'b0,1'b1,4'd2,8'd15,1'b1,8'd5, 1'b0});
    vecs.push_back('{1'b0,1'b0,1'b0,4'd0, 4'd0, 8'd0,  1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,4'd2,8'd15,1'b1,8'd15,1'b1});
    vecs.push_back('{1'b0,1'b0,1'b0,4'd0, 4'd0, 8'd0,  1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,4'd2,8'd15,1'b0,8'd0, 1'b0});
    // single-beat read (len 0) of address 2
    vecs.push_back('{1'b0,1'b1,1'b0,4'd2, 4'd0, 8'd0,  1'b0, 1'b0,1'b0,1'b1,1'b0,1'b1,4'd2,8'd15,1'b0,8'd0, 1'b0});
    vecs.push_back('{1'b0,1'b0,1'b0,4'd0, 4'd0, 8'd0,  1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,4'd2,8'd15,1'b1,8'd15,1'b1});
    vecs.push_back('{1'b0,1'b0,1'b0,4'd0, 4'd0, 8'd0,  1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,4'd2,8'd15,1'b0,8'd0, 1'b0});

    foreach (vecs[i]) begin
      rst = vecs[i].rst; cmd_valid = vecs[i].cv; cmd_wr = vecs[i].cwr;
      cmd_addr = vecs[i].ca; cmd_len = vecs[i].cl; wdata = vecs[i].wd; wvalid = vecs[i].wv;
      tick();
      act_p = {cmd_ready, busy, wready, en_ram, we_ram, re_ram, addr_ram, wdata_ram, rvalid, rdata, done};
      exp_p = {vecs[i].rdy, ~vecs[i].rdy, vecs[i].wrdy, vecs[i].en, vecs[i].we, vecs[i].re,
               vecs[i].aram, vecs[i].wdram, vecs[i].rv, vecs[i].rd, vecs[i].dn};
      chk($sformatf("vec%0d", i), act_p, exp_p);
    end
    idle_inputs();

    // Wrapping write at 14 len 3, then readback.
    wrap_a = '{4'd14, 4'd15, 4'd0, 4'd1};
    wrap_d = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    clear_mon();
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 4'd14; cmd_len = 4'd3;
    tick();
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      wvalid = 1'b1; wdata = wrap_d[k];
      tick();
    end
    idle_inputs();
    wait_idle("wrap_wr_idle");
    chk("wrap_wr_n", wr_addr_q.size(), 4);
    for (int k = 0; k < 4 && k < wr_addr_q.size(); k++) begin
      chk($sformatf("wrap_wr_addr%0d", k), wr_addr_q[k], wrap_a[k]);
      chk($sformatf("wrap_wr_data%0d", k), wr_data_q[k], wrap_d[k]);
    end
    chk("wrap_wr_done", done_cnt, 1);
    clear_mon();
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 4'd14; cmd_len = 4'd3;
    tick();
    idle_inputs();
    wait_idle("wrap_rd_idle");
    tick();
    chk("wrap_rd_n", rd_addr_q.size(), 4);
    chk("wrap_rv_n", rv_data_q.size(), 4);
    for (int k = 0; k < 4 && k < rd_addr_q.size() && k < rv_data_q.size(); k++) begin
      chk($sformatf("wrap_rd_addr%0d", k), rd_addr_q[k], wrap_a[k]);
      chk($sformatf("wrap_rd_data%0d", k), rv_data_q[k], wrap_d[k]);
    end
    chk("wrap_rd_done", done_cnt, 1);

    // Write with two stall cycles after beat 1.
    clear_mon();
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 4'd5; cmd_len = 4'd3;
    tick();
    idle_inputs();
    wvalid = 1'b1; wdata = 8'h31;
    tick();
    wvalid = 1'b0;
    tick();
    chk("stall_en1", {en_ram, addr_ram, wdata_ram}, {1'b0, 4'd5, 8'h31});
    tick();
    chk("stall_en2", {en_ram, addr_ram, wready}, {1'b0, 4'd5, 1'b1});
    for (int k = 0; k < 3; k++) begin
      wvalid = 1'b1; wdata = 8'h32 + 8'(k);
      tick();
    end
    idle_inputs();
    wait_idle("stall_idle");
    chk("stall_n", wr_addr_q.size(), 4);
    if (wr_addr_q.size() == 4)
      chk("stall_addrs", {wr_addr_q[0], wr_addr_q[1], wr_addr_q[2], wr_addr_q[3]},
          {4'd5, 4'd6, 4'd7, 4'd8});
    chk("stall_done", done_cnt, 1);

    // Command offered during a read burst is ignored.
    clear_mon();
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 4'd0; cmd_len = 4'd3;
    tick();
    cmd_wr = 1'b1; cmd_addr = 4'd9; cmd_len = 4'd0;
    tick();
    chk("busy_ready", {cmd_ready, busy, wready}, {1'b0, 1'b1, 1'b0});
    tick();
    idle_inputs();
    wait_idle("busy_idle");
    tick();
    tick();
    chk("busy_rd_n", rd_addr_q.size(), 4);
    chk("busy_wr_n", wr_addr_q.size(), 0);
    chk("busy_rv_n", rv_data_q.size(), 4);
    chk("busy_done", done_cnt, 1);
    chk("busy_after", {cmd_ready, en_ram, busy}, {1'b1, 1'b0, 1'b0});

    // Reset in the middle of a read burst.
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 4'd0; cmd_len = 4'd7;
    tick();
    idle_inputs();
    tick();
    tick();
    chk("rst_pre_rvalid", rvalid, 1'b1);
    rst = 1'b1;
    tick();
    chk("rst_mid", {rvalid, en_ram, re_ram, cmd_ready, busy, done}, {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    rst = 1'b0;
    clear_mon();
    for (int k = 0; k < 5; k++) tick();
    chk("rst_no_done", done_cnt, 0);
    chk("rst_no_rv", rv_data_q.size(), 0);
    chk("rst_no_strobe", rd_addr_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
